// File: rtl/pipelined_tree_multiplier_if.sv
// Operand/product handshake bundle for pipelined_tree_multiplier.
// The master drives operands and accepts products; the slave is the multiplier.
interface pipelined_tree_multiplier_if #(
  parameter int WIDTH = 8
);
  localparam int OUT_W = 2 * WIDTH;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             sgn;
  logic             o_valid;
  logic             o_ready;
  logic [OUT_W-1:0] o;

  modport master (
    output in_valid, x, y, sgn, o_ready,
    input  in_ready, o_valid, o
  );

  modport slave (
    input  in_valid, x, y, sgn, o_ready,
    output in_ready, o_valid, o
  );
endinterface

// File: rtl/pipelined_tree_multiplier.sv
// Three-stage multiplier: Baugh-Wooley partial products, carry-save reduction
// to two rows, Kogge-Stone final add. One product per cycle, global stall.
module pipelined_tree_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  pipelined_tree_multiplier_if.slave    bus,
  output logic                          busy
);
  localparam int OUT_W  = 2 * WIDTH;
  localparam int LEVELS = $clog2(OUT_W);

  typedef logic [OUT_W-1:0] row_t;

  logic adv;
  logic accept;

  logic s1_valid, s2_valid, s3_valid;
  logic s1_sgn, s2_sgn;
  row_t s1_pp [WIDTH];
  row_t s2_sum, s2_carry;
  row_t o_q;

  row_t pp_next [WIDTH];
  row_t red_sum, red_carry;
  row_t ks_sum;

  assign adv          = !s3_valid || bus.o_ready;
  assign accept       = bus.in_valid && adv;
  assign bus.in_ready = adv;
  assign bus.o_valid  = s3_valid;
  assign bus.o        = o_q;
  assign busy         = s1_valid || s2_valid || s3_valid;

  // S1: AND array; in signed mode the bits pairing exactly one operand MSB are
  // inverted. The matching constants (2^WIDTH, 2^(OUT_W-1)) are added later.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      pp_next[i] = '0;
      for (int j = 0; j < WIDTH; j++) begin
        pp_next[i][i+j] = (bus.x[j] & bus.y[i]) ^
                          (bus.sgn && ((i == WIDTH-1) != (j == WIDTH-1)));
      end
    end
  end

  // S2: full-adder rows fold every partial product, plus the 2^WIDTH
  // correction, into one sum row and one carry row.
  always_comb begin
    row_t acc_s, acc_c, t, corr;
    // NOTE: blocking assignments here model a chain of combinational
    // temporaries inside one cycle; every variable is written before use, so
    // no latch is inferred.
    acc_s = s1_pp[0];
    acc_c = s1_pp[1];
    for (int k = 2; k < WIDTH; k++) begin
      t     = acc_s ^ acc_c ^ s1_pp[k];
      acc_c = ((acc_s & acc_c) | (acc_s & s1_pp[k]) | (acc_c & s1_pp[k])) << 1;
      acc_s = t;
    end
    corr        = '0;
    corr[WIDTH] = s1_sgn;
    red_sum     = acc_s ^ acc_c ^ corr;
    red_carry   = ((acc_s & acc_c) | (acc_s & corr) | (acc_c & corr)) << 1;
  end

  // S3: Kogge-Stone prefix over generate/propagate.
  always_comb begin
    row_t g, p, gn, pn;
    g = s2_sum & s2_carry;
    p = s2_sum ^ s2_carry;
    for (int l = 0; l < LEVELS; l++) begin
      gn = g;
      pn = p;
      for (int i = (1 << l); i < OUT_W; i++) begin
        gn[i] = g[i] | (p[i] & g[i - (1 << l)]);
        pn[i] = p[i] & p[i - (1 << l)];
      end
      g = gn;
      p = pn;
    end
    ks_sum = (s2_sum ^ s2_carry) ^ {g[OUT_W-2:0], 1'b0};
  end

  // Control state and the visible product register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      o_q      <= '0;
    end else if (adv) begin
      s1_valid <= accept;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
      // Adding 2^(OUT_W-1) modulo 2^OUT_W is a flip of the top bit.
      if (s2_valid) o_q <= ks_sum ^ {s2_sgn, {(OUT_W-1){1'b0}}};
    end
  end

  // NOTE: intermediate data registers are deliberately not reset; they are
  // only ever consumed when the matching valid bit is set, and that is reset.
  always_ff @(posedge clk) begin
    if (adv) begin
      if (accept) begin
        s1_pp  <= pp_next;
        s1_sgn <= bus.sgn;
      end
      if (s1_valid) begin
        s2_sum   <= red_sum;
        s2_carry <= red_carry;
        s2_sgn   <= s1_sgn;
      end
    end
  end
endmodule

// File: tb/tb_pipelined_tree_multiplier.sv
// Directed and model-checked bench for pipelined_tree_multiplier (WIDTH 8 and
// an exhaustive WIDTH 4 instance).
module tb_pipelined_tree_multiplier;
  logic clk = 1'b0;
  logic rst;
  logic busy8, busy4;

  pipelined_tree_multiplier_if #(.WIDTH(8)) m8 ();
  pipelined_tree_multiplier_if #(.WIDTH(4)) m4 ();

  pipelined_tree_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .bus(m8), .busy(busy8)
  );
  pipelined_tree_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .bus(m4), .busy(busy4)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_q [$];
  logic        fired;
  logic        took;
  int          fires = 0;

  logic [7:0]  dx [8] = '{8'h80, 8'hFF, 8'hFF, 8'h7F, 8'h80, 8'hFF, 8'hF0, 8'h00};
  logic [7:0]  dy [8] = '{8'h80, 8'h01, 8'h01, 8'h80, 8'hFF, 8'hFF, 8'h02, 8'h55};
  logic        ds [8] = '{1'b1,  1'b1,  1'b0,  1'b1,  1'b1,  1'b1,  1'b0,  1'b0};
  logic [15:0] de [8] = '{16'h4000, 16'hFFFF, 16'h00FF, 16'hC080,
                          16'h0080, 16'h0001, 16'h01E0, 16'h0000};

  logic [7:0]  exp4 [515];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
    if (s) return 16'($signed({{8{a[7]}}, a}) * $signed({{8{b[7]}}, b}));
    return {8'h00, a} * {8'h00, b};
  endfunction

  function automatic logic [7:0] ref4(input logic [3:0] a, input logic [3:0] b, input logic s);
    if (s) return 8'($signed({{4{a[3]}}, a}) * $signed({{4{b[3]}}, b}));
    return {4'h0, a} * {4'h0, b};
  endfunction

  // One cycle on the 8-bit instance: drive, scoreboard the output handshake,
  // record acceptance, then step past the next rising edge.
  task automatic tick8(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic s, input logic r, input logic [15:0] e);
    m8.in_valid = v;
    m8.x        = a;
    m8.y        = b;
    m8.sgn      = s;
    m8.o_ready  = r;
    #1;
    took  = v && m8.in_ready;
    fired = m8.o_valid && r;
    if (fired) begin
      fires++;
      if (exp_q.size() == 0) check("spurious_out", 32'(m8.o_valid), 32'd0);
      else                   check("prod_order", 32'(m8.o), 32'(exp_q.pop_front()));
    end
    if (took) exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a, b;
    logic       s, v, r;
    int         f0, n;

    rst = 1'b1;
    m8.in_valid = 1'b0; m8.x = '0; m8.y = '0; m8.sgn = 1'b0; m8.o_ready = 1'b1;
    m4.in_valid = 1'b0; m4.x = '0; m4.y = '0; m4.sgn = 1'b0; m4.o_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_o_valid", 32'(m8.o_valid), 32'd0);
    check("rst_busy",    32'(busy8),      32'd0);
    check("rst_o",       32'(m8.o),       32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_in_ready", 32'(m8.in_ready), 32'd1);

    // Latency: 0xFF * 0xFF unsigned appears after exactly three edges.
    m8.in_valid = 1'b1; m8.x = 8'hFF; m8.y = 8'hFF; m8.sgn = 1'b0; m8.o_ready = 1'b1;
    #1;
    check("lat_in_ready", 32'(m8.in_ready), 32'd1);
    @(posedge clk); #1;
    m8.in_valid = 1'b0;
    check("lat_edge1_valid", 32'(m8.o_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_edge2_valid", 32'(m8.o_valid), 32'd0);
    check("lat_busy",        32'(busy8),      32'd1);
    @(posedge clk); #1;
    check("lat_edge3_valid", 32'(m8.o_valid), 32'd1);
    check("lat_product",     32'(m8.o),       32'h0000FE01);
    @(posedge clk); #1;
    check("bubble_valid", 32'(m8.o_valid), 32'd0);
    check("bubble_hold",  32'(m8.o),       32'h0000FE01);
    check("bubble_busy",  32'(busy8),      32'd0);

    // Directed corner products, back to back with mixed modes.
    for (int k = 0; k < 8; k++) tick8(1'b1, dx[k], dy[k], ds[k], 1'b1, de[k]);
    repeat (4) tick8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 16'h0000);
    check("directed_drained", 32'(exp_q.size()), 32'd0);

    // Ten random pairs streamed: ten consecutive valid outputs.
    fires = 0;
    for (int k = 0; k < 13; k++) begin
      a = 8'($urandom); b = 8'($urandom); s = 1'($urandom_range(0, 1));
      tick8(k < 10, a, b, s, 1'b1, ref8(a, b, s));
      if (k >= 3) check("b2b_valid", 32'(fired), 32'd1);
    end
    check("b2b_count", 32'(fires), 32'd10);

    // Stall: three fill the pipe, the fourth waits for o_ready.
    fires = 0;
    tick8(1'b1, 8'h03, 8'h07, 1'b0, 1'b0, 16'h0015);
    check("stall_acc_a", 32'(took), 32'd1);
    tick8(1'b1, 8'hF0, 8'h02, 1'b1, 1'b0, 16'hFFE0);
    tick8(1'b1, 8'h10, 8'h10, 1'b0, 1'b0, 16'h0100);
    for (int k = 0; k < 2; k++) begin
      tick8(1'b1, 8'h81, 8'h7F, 1'b1, 1'b0, 16'hC0FF);
      check("stall_in_ready", 32'(took),       32'd0);
      check("stall_o_valid",  32'(m8.o_valid), 32'd1);
      check("stall_hold",     32'(m8.o),       32'h00000015);
    end
    n = 0;
    do begin
      tick8(1'b1, 8'h81, 8'h7F, 1'b1, 1'b1, 16'hC0FF);
      n++;
    end while (!took && n < 8);
    check("stall_d_accepted", 32'(took), 32'd1);
    repeat (5) tick8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 16'h0000);
    check("stall_count", 32'(fires), 32'd4);
    check("stall_drained", 32'(exp_q.size()), 32'd0);

    // Reset with three in flight, plus a transaction presented during reset.
    tick8(1'b1, 8'h11, 8'h11, 1'b0, 1'b1, 16'h0121);
    tick8(1'b1, 8'h22, 8'h03, 1'b0, 1'b1, 16'h0066);
    tick8(1'b1, 8'h05, 8'h05, 1'b0, 1'b1, 16'h0019);
    m8.in_valid = 1'b1; m8.x = 8'h03; m8.y = 8'h05; m8.sgn = 1'b0; m8.o_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m8.in_valid = 1'b0;
    check("flush_o_valid", 32'(m8.o_valid), 32'd0);
    check("flush_busy",    32'(busy8),      32'd0);
    check("flush_o",       32'(m8.o),       32'd0);
    check("flush_in_ready", 32'(m8.in_ready), 32'd1);
    exp_q.delete();
    f0 = fires;
    repeat (4) tick8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 16'h0000);
    check("flush_no_stale", 32'(fires - f0), 32'd0);
    tick8(1'b1, 8'h03, 8'h05, 1'b0, 1'b1, 16'h000F);
    repeat (4) tick8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 16'h0000);
    check("post_rst_count", 32'(fires - f0), 32'd1);
    check("post_rst_drained", 32'(exp_q.size()), 32'd0);

    // Random traffic with random back-pressure against the reference model.
    for (int k = 0; k < 400; k++) begin
      a = 8'($urandom); b = 8'($urandom); s = 1'($urandom_range(0, 1));
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      tick8(v, a, b, s, r, ref8(a, b, s));
    end
    repeat (8) tick8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 16'h0000);
    check("random_drained", 32'(exp_q.size()), 32'd0);

    // WIDTH=4 exhaustive, both modes, one operand pair per cycle.
    for (int k = 0; k < 515; k++) begin
      logic [8:0] nv;
      nv = 9'(k);
      m4.o_ready = 1'b1;
      if (k < 512) begin
        m4.in_valid = 1'b1;
        m4.sgn      = nv[8];
        m4.x        = nv[7:4];
        m4.y        = nv[3:0];
        exp4[k]     = ref4(nv[7:4], nv[3:0], nv[8]);
      end else begin
        m4.in_valid = 1'b0;
      end
      #1;
      if (k >= 3) begin
        check("w4_valid", 32'(m4.o_valid), 32'd1);
        check("w4_prod",  32'(m4.o),       32'(exp4[k-3]));
      end
      @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipelined_tree_multiplier.md
PIPELINED_TREE_MULTIPLIER -- requirements
Module: pipelined_tree_multiplier

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand width in bits; legal range 4..32.
REQ-002 The block SHALL have parameter OUT_W, fixed at 2*WIDTH, product width; not overridable.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port in_valid  input  1  operands present on x, y, sgn.
REQ-006 The block SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 The block SHALL have port x  input  WIDTH  multiplicand.
REQ-008 The block SHALL have port y  input  WIDTH  multiplier.
REQ-009 The block SHALL have port sgn  input  1  0 = unsigned, 1 = two's-complement signed, per transaction.
REQ-010 The block SHALL have port o_valid  output  1  product present on o.
REQ-011 The block SHALL have port o_ready  input  1  consumer accepts product this cycle.
REQ-012 The block SHALL have port o  output  OUT_W  product.
REQ-013 The block SHALL have port busy  output  1  at least one transaction in flight.

Function
REQ-014 The pipeline SHALL be three register stages: S1 partial-product generation (AND array, Baugh-Wooley sign correction when sgn=1), S2 full/half-adder column reduction to two rows, S3 final parallel-prefix add (Kogge-Stone style generate/propagate).
REQ-015 Each stage SHALL carry its own valid bit and the sgn bit of its transaction.
REQ-016 The pipeline SHALL advance only when adv = !o_valid || o_ready, and all stages SHALL hold when adv = 0 (global stall).
REQ-017 in_ready SHALL equal adv combinationally; a transaction SHALL be accepted when in_valid && in_ready.
REQ-018 Latency SHALL be exactly 3 cycles from acceptance to o_valid with no stall, and throughput SHALL be one product per cycle.
REQ-019 o SHALL equal x*y mod 2^OUT_W for sgn=0 and the signed product as OUT_W-bit two's complement for sgn=1, with no overflow possible.
REQ-020 o and o_valid SHALL remain stable while o_valid && !o_ready.
REQ-021 Bubbles (in_valid=0 while adv=1) SHALL propagate as invalid stages; o SHALL NOT change when a bubble reaches S3 (data registers load only on valid).
REQ-022 busy SHALL be the OR of the three stage valid bits.
REQ-023 Transactions SHALL exit in acceptance order, with no drop or duplication under any o_ready pattern.
REQ-024 Mixed sgn values in consecutive transactions SHALL each be computed with their own mode.

Reset
REQ-025 While rst=1 all stage valid bits SHALL clear to 0, o SHALL be 0, o_valid 0, busy 0, and in_ready 1 on the cycle after rst deasserts.
REQ-026 Reset mid-operation SHALL discard all in-flight transactions, and no stale product SHALL appear after reset.
REQ-027 A transaction presented in the same cycle as rst=1 SHALL NOT be accepted.

Verification
REQ-028 WIDTH=8, sgn=0, x=0xFF, y=0xFF, o_ready=1 -> o=0xFE01, o_valid high exactly 3 cycles after acceptance.
REQ-029 WIDTH=8, sgn=1, x=0x80, y=0x80 -> o=0x4000; then x=0xFF, y=0x01 -> o=0xFFFF; x=0xFF, y=0x01, sgn=0 -> o=0x00FF.
REQ-030 Back-to-back stream of 10 random operand pairs, o_ready=1 -> 10 consecutive o_valid cycles, products in order and matching the reference model.
REQ-031 o_ready held 0 for 5 cycles with 4 accepted transactions -> in_ready=0 once the pipeline is full, o held constant; after o_ready=1, all 4 products in order, none lost.
REQ-032 rst pulsed for 1 cycle with 3 transactions in flight -> o_valid=0 and busy=0 afterwards, no product emitted for the flushed transactions; the next accepted 3x5 (sgn=0) yields o=15.
REQ-033 Sweep WIDTH in {4, 8, 16}: exhaustive for WIDTH=4 in both modes (512 cases), random 10^4 cases per mode otherwise -> zero mismatches.
